// File: rtl/glitch_sweep_ctrl_pkg.sv
// Shared types and constants for the glitch delay sweep sequencer.
package glitch_pkg;

  localparam int DELAY_W_DEFAULT = 32;
  localparam int REP_W_DEFAULT   = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_FIRE = 3'd3,
    S_COOL = 3'd4,
    S_STEP = 3'd5,
    S_DONE = 3'd6
  } sweep_state_t;

  // Width of a down-counter able to hold the value 'cycles' (at least 1 bit).
  function automatic int timer_width(input int cycles);
    if (cycles < 2) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/glitch_sweep_ctrl_if.sv
// Link between the sweep sequencer and trigger_delay.
// The sequencer (master) drives delay/set_delay/trig_gated; trigger_delay
// (slave) returns delayed_trigger. set_delay is a one-cycle load strobe:
// trigger_delay captures delay in every cycle where set_delay is high,
// there is no back-pressure.
interface glitch_sweep_ctrl_if
  import glitch_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEFAULT
) ();

  logic [DELAY_W-1:0] delay;
  logic               set_delay;
  logic               trig_gated;
  logic               delayed_trigger;

  modport master (
    output delay,
    output set_delay,
    output trig_gated,
    input  delayed_trigger
  );

  modport slave (
    input  delay,
    input  set_delay,
    input  trig_gated,
    output delayed_trigger
  );

endinterface

// File: rtl/glitch_sweep_ctrl_cycle_timer.sv
// Loadable down-counter that stops at zero and flags it.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over counting; the count holds once it reaches zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Sweeps the trigger_delay delay from cfg_start to cfg_end in cfg_step
// increments, firing cfg_repeats gated attempts per point with a cooldown
// after each attempt.
module glitch_sweep_ctrl
  import glitch_pkg::*;
#(
  parameter int DELAY_W         = DELAY_W_DEFAULT,
  parameter int REP_W           = REP_W_DEFAULT,
  parameter int COOLDOWN_CYCLES = 1000,  // must be >= 1
  parameter int TIMEOUT_CYCLES  = 0      // 0 disables the ARM timeout
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DELAY_W-1:0]  cfg_start,
  input  logic [DELAY_W-1:0]  cfg_end,
  input  logic [DELAY_W-1:0]  cfg_step,
  input  logic [REP_W-1:0]    cfg_repeats,
  input  logic                trigger_in,
  glitch_sweep_ctrl_if.master trig_if,
  output logic                busy,
  output logic                attempt_done,
  output logic                attempt_timeout,
  output logic                done,
  output logic                aborted,
  output logic [DELAY_W-1:0]  cur_delay,
  output logic [REP_W-1:0]    attempt_cnt,
  output sweep_state_t        fsm_state
);

  localparam int COOL_W = timer_width(COOLDOWN_CYCLES);
  localparam int TO_W   = timer_width(TIMEOUT_CYCLES);
  // The cooldown timer is loaded on the transition into COOL, so COOL lasts
  // load value + 1 cycles.
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES - 1);
  // The timeout timer is loaded on ARM entry and expires TIMEOUT_CYCLES
  // cycles later.
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES);
  localparam bit                TO_EN     = (TIMEOUT_CYCLES != 0);

  sweep_state_t state_q, state_d;

  logic [DELAY_W-1:0] cfg_end_q, cfg_step_q, cur_delay_q;
  logic [REP_W-1:0]   rep_target_q, rep_q, rep_inc, attempt_cnt_q;
  logic               timeout_q, aborted_q;
  logic [DELAY_W:0]   next_sum;
  logic               empty_range;

  logic capture, advance, attempt_end, abort_take, set_timeout;
  logic cool_load, cool_en, cool_zero;
  logic to_load, to_en, to_zero;
  logic arm;

  assign next_sum    = {1'b0, cur_delay_q} + {1'b0, cfg_step_q};
  assign rep_inc     = rep_q + 1'b1;
  assign empty_range = (cfg_start > cfg_end);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    advance     = 1'b0;
    attempt_end = 1'b0;
    abort_take  = 1'b0;
    set_timeout = 1'b0;
    cool_load   = 1'b0;
    cool_en     = 1'b0;
    to_load     = 1'b0;
    to_en       = 1'b0;
    // DONE is excluded so a held abort cannot pin the FSM in DONE; the done
    // pulse is already under way there.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d    = S_DONE;
      abort_take = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            capture = 1'b1;
            state_d = empty_range ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          to_load = 1'b1;
          state_d = S_ARM;
        end
        S_ARM: begin
          to_en = 1'b1;
          if (trig_if.delayed_trigger) begin
            state_d = S_FIRE;
          end else if (TO_EN && to_zero) begin
            state_d     = S_COOL;
            cool_load   = 1'b1;
            set_timeout = 1'b1;
          end
        end
        S_FIRE: begin
          if (!trig_if.delayed_trigger) begin
            state_d   = S_COOL;
            cool_load = 1'b1;
          end
        end
        S_COOL: begin
          if (cool_zero) begin
            attempt_end = 1'b1;
            if (rep_inc == rep_target_q) begin
              state_d = S_STEP;
            end else begin
              state_d = S_ARM;
              to_load = 1'b1;
            end
          end else begin
            cool_en = 1'b1;
          end
        end
        S_STEP: begin
          if ((cfg_step_q == '0) || next_sum[DELAY_W] ||
              (next_sum[DELAY_W-1:0] > cfg_end_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            advance = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Sweep datapath: captured config, current point and attempt bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_end_q     <= '0;
      cfg_step_q    <= '0;
      rep_target_q  <= '0;
      cur_delay_q   <= '0;
      rep_q         <= '0;
      attempt_cnt_q <= '0;
      timeout_q     <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      if (capture) begin
        cfg_end_q     <= cfg_end;
        cfg_step_q    <= cfg_step;
        rep_target_q  <= (cfg_repeats == '0) ? REP_W'(1) : cfg_repeats;
        rep_q         <= '0;
        attempt_cnt_q <= '0;
        aborted_q     <= 1'b0;
        if (!empty_range) begin
          cur_delay_q <= cfg_start;
        end
      end
      if (advance) begin
        cur_delay_q <= next_sum[DELAY_W-1:0];
        rep_q       <= '0;
      end
      if (attempt_end) begin
        rep_q <= rep_inc;
        if (attempt_cnt_q != '1) begin
          attempt_cnt_q <= attempt_cnt_q + 1'b1;
        end
      end
      if (to_load) begin
        timeout_q <= 1'b0;
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
      if (abort_take) begin
        aborted_q <= 1'b1;
      end
    end
  end

  cycle_timer #(.W(COOL_W)) u_cool_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (cool_load),
    .load_val (COOL_LOAD),
    .en       (cool_en),
    .zero     (cool_zero)
  );

  cycle_timer #(.W(TO_W)) u_timeout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .en       (to_en),
    .zero     (to_zero)
  );

  // arm is a state decode, dropped combinationally by abort so the target
  // trigger is cut off in the same cycle.
  assign arm                = ((state_q == S_ARM) || (state_q == S_FIRE)) && !abort;
  assign trig_if.trig_gated = trigger_in & arm;
  assign trig_if.set_delay  = (state_q == S_LOAD);
  assign trig_if.delay      = cur_delay_q;

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign aborted         = done & aborted_q;
  assign attempt_done    = attempt_end;
  assign attempt_timeout = attempt_end & timeout_q;
  assign cur_delay       = cur_delay_q;
  assign attempt_cnt     = attempt_cnt_q;
  assign fsm_state       = state_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Bench for glitch_sweep_ctrl with a behavioural trigger_delay model.
module tb_glitch_sweep_ctrl;
  import glitch_pkg::*;

  localparam int DW   = 32;
  localparam int RW   = 16;
  localparam int COOL = 4;
  localparam int TOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, trigger_in;
  logic [DW-1:0] cfg_start, cfg_end, cfg_step;
  logic [RW-1:0] cfg_repeats;
  logic          busy, attempt_done, attempt_timeout, done, aborted;
  logic [DW-1:0] cur_delay;
  logic [RW-1:0] attempt_cnt;
  sweep_state_t  fsm_state;

  glitch_sweep_ctrl_if #(.DELAY_W(DW)) tif ();

  glitch_sweep_ctrl #(
    .DELAY_W(DW), .REP_W(RW), .COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_step(cfg_step),
    .cfg_repeats(cfg_repeats), .trigger_in(trigger_in), .trig_if(tif),
    .busy(busy), .attempt_done(attempt_done), .attempt_timeout(attempt_timeout),
    .done(done), .aborted(aborted), .cur_delay(cur_delay),
    .attempt_cnt(attempt_cnt), .fsm_state(fsm_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // trigger_delay model: after the gated trigger has been high 3 cycles,
  // output a 2-cycle delayed pulse; returns to idle when the gate drops.
  bit mdl_en = 1'b1;
  int mdl_cnt = 0;
  always @(posedge clk) begin
    if (!tif.trig_gated) begin
      mdl_cnt <= 0;
      tif.delayed_trigger <= 1'b0;
    end else begin
      mdl_cnt <= mdl_cnt + 1;
      tif.delayed_trigger <= mdl_en && (mdl_cnt >= 2) && (mdl_cnt < 4);
    end
  end

  // Scoreboard: expected set_delay values and done records {aborted, attempt_cnt}.
  logic [DW-1:0] exp_delay_q[$];
  logic [RW:0]   exp_done_q[$];
  int n_set = 0, n_att = 0, n_to = 0, n_done = 0;
  int set_cyc = 0, done_cyc = 0;
  logic [DW-1:0] done_cur;

  always @(negedge clk) begin
    if (rst) begin
      if (tif.set_delay) begin
        n_set++;
        set_cyc = cyc;
        if (exp_delay_q.size() == 0) check("set_delay_unexpected", 1, 0);
        else check("set_delay_value", tif.delay, exp_delay_q.pop_front());
      end
      if (attempt_done) begin
        n_att++;
        if (attempt_timeout) n_to++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        done_cur = cur_delay;
        if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_record", {aborted, attempt_cnt}, exp_done_q.pop_front());
      end
    end
  end

  // Driver tasks.
  int start_cyc = 0;
  task automatic start_sweep(input logic [DW-1:0] s, input logic [DW-1:0] e,
                             input logic [DW-1:0] st, input logic [RW-1:0] r);
    @(posedge clk); #1;
    cfg_start = s; cfg_end = e; cfg_step = st; cfg_repeats = r;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble config to show it was captured on start.
    cfg_start = $urandom(); cfg_end = $urandom(); cfg_step = $urandom();
    cfg_repeats = RW'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int budget);
    int seen0 = n_done;
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_done != seen0) begin got = 1'b1; break; end
    end
    check("done_wait", got, 1);
  endtask

  task automatic wait_attempt(input int budget, output int c, output logic to);
    bit got = 1'b0;
    c = 0; to = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (attempt_done) begin got = 1'b1; c = cyc; to = attempt_timeout; break; end
    end
    check("attempt_wait", got, 1);
  endtask

  task automatic wait_signal_level(input string tag, input bit want_trig, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (want_trig ? (tif.delayed_trigger === 1'b1) : (tif.trig_gated === 1'b0)) begin
        got = 1'b1; break;
      end
    end
    check(tag, got, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_outs"}, {tif.set_delay, tif.trig_gated, attempt_done,
                           attempt_timeout, done, aborted}, 0);
    check({tag, "_delay"}, tif.delay, 0);
    check({tag, "_cur_delay"}, cur_delay, 0);
    check({tag, "_attempt_cnt"}, attempt_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a0, t0, s0, c1, c2, d0;
  logic to1, to2;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; trigger_in = 1'b1;
    cfg_start = '0; cfg_end = '0; cfg_step = '0; cfg_repeats = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Main sweep: 3 points x 2 repeats.
    a0 = n_att; t0 = n_to;
    exp_delay_q.push_back(32'h10); exp_delay_q.push_back(32'h11); exp_delay_q.push_back(32'h12);
    exp_done_q.push_back({1'b0, 16'd6});
    start_sweep(32'h10, 32'h12, 32'd1, 16'd2);
    wait_done(500);
    check("main_attempts", n_att - a0, 6);
    check("main_no_timeout", n_to - t0, 0);
    @(negedge clk); #1;
    check("main_idle_busy", busy, 0);

    // Empty range: done one cycle after start, no load strobe.
    s0 = n_set;
    exp_done_q.push_back({1'b0, 16'd0});
    start_sweep(32'd5, 32'd3, 32'd1, 16'd1);
    wait_done(10);
    check("empty_latency", done_cyc - start_cyc, 1);
    check("empty_no_set", n_set - s0, 0);

    // Carry ends the sweep after one point; repeats=0 acts as 1.
    exp_delay_q.push_back(32'hFFFF_FFFE);
    exp_done_q.push_back({1'b0, 16'd1});
    start_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd4, 16'd0);
    wait_done(200);
    check("carry_cur_delay", done_cur, 32'hFFFF_FFFE);

    // next > end ends the sweep: points 0, 2, 4 with end 5.
    exp_delay_q.push_back(32'd0); exp_delay_q.push_back(32'd2); exp_delay_q.push_back(32'd4);
    exp_done_q.push_back({1'b0, 16'd3});
    start_sweep(32'd0, 32'd5, 32'd2, 16'd1);
    wait_done(300);
    check("range_cur_delay", done_cur, 32'd4);

    // Timeout: delayed_trigger never rises.
    mdl_en = 1'b0;
    exp_delay_q.push_back(32'h20);
    exp_done_q.push_back({1'b0, 16'd2});
    start_sweep(32'h20, 32'h20, 32'd1, 16'd2);
    wait_attempt(100, c1, to1);
    check("timeout_flag1", to1, 1);
    check("timeout_latency1", c1 - set_cyc, 1 + TOUT + COOL);
    @(negedge clk); #1;
    check("timeout_rearm", tif.trig_gated, 1);
    wait_attempt(100, c2, to2);
    check("timeout_flag2", to2, 1);
    check("timeout_latency2", c2 - c1, 1 + TOUT + COOL);
    wait_done(50);
    mdl_en = 1'b1;

    // Abort during FIRE.
    exp_delay_q.push_back(32'h30);
    start_sweep(32'h30, 32'h40, 32'd1, 16'd3);
    wait_signal_level("abort_wait_trig", 1'b1, 50);
    @(posedge clk); #1;
    check("fire_trig_gated", tif.trig_gated, 1);
    abort = 1'b1;
    exp_done_q.push_back({1'b1, 16'd0});
    #1;
    check("abort_trig_gated", tif.trig_gated, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(3);
    @(negedge clk); #1;
    check("abort_idle_busy", busy, 0);

    // start and abort together in IDLE: abort wins.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk); #1;
    check("start_abort_busy", busy, 0);

    // Asynchronous reset mid-COOL.
    exp_delay_q.push_back(32'h50);
    start_sweep(32'h50, 32'h50, 32'd1, 16'd1);
    wait_signal_level("cool_wait_trig", 1'b1, 50);
    wait_signal_level("cool_wait_gate", 1'b0, 50);
    d0 = n_done;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midcool_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midcool_no_done", n_done - d0, 0);

    // Fresh sweep after reset.
    exp_delay_q.push_back(32'd1); exp_delay_q.push_back(32'd2);
    exp_done_q.push_back({1'b0, 16'd2});
    start_sweep(32'd1, 32'd2, 32'd1, 16'd1);
    wait_done(200);

    repeat (3) @(negedge clk);
    check("exp_delay_left", exp_delay_q.size(), 0);
    check("exp_done_left", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
